// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus for imem_loader.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1; the source holds byte_data stable while byte_valid is 1 and unaccepted.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed big-endian word image into instruction memory while holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_DAT_HI = 4'd3,
    S_DAT_LO = 4'd4,
    S_WRITE  = 4'd5,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK    = 4'd6,
`endif
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_d;
  logic [15:0] len_q;
  logic [7:0]  hi_q;
  logic        xfer;
  logic        can_start;
  logic [15:0] len_full;
  logic [16:0] wc_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign len_full  = {len_q[15:8], bus.byte_data};
  assign wc_next   = {1'b0, word_count} + 17'd1;
  assign dbg_state = state;

  function automatic logic takes_bytes(state_t s);
    logic r;
    r = (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) || (s == S_DAT_LO);
`ifdef IMEM_LOADER_CHECKSUM_EN
    r = r || (s == S_CHK);
`endif
    return r;
  endfunction

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full == 16'd0)                state_d = S_DONE;
          else if ({1'b0, len_full} > MAX_N)    state_d = S_ERR;
          else                                  state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: if (xfer) state_d = S_DAT_LO;
      S_DAT_LO: if (xfer) state_d = S_WRITE;
      S_WRITE: begin
        if (wc_next < {1'b0, len_q}) state_d = S_DAT_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else                         state_d = S_CHK;
`else
        else                         state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (xfer) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state          <= S_IDLE;
      len_q          <= 16'd0;
      hi_q           <= 8'd0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 16'd0;
      bus.mem_wdata  <= 16'd0;
      word_count     <= 16'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      cpu_rst_n      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q         <= 8'd0;
`endif
    end else begin
      state          <= state_d;
      bus.byte_ready <= takes_bytes(state_d);
      bus.mem_we     <= (state_d == S_WRITE);
      busy           <= takes_bytes(state_d) || (state_d == S_WRITE);
      done           <= (state_d == S_DONE);
      err            <= (state_d == S_ERR);
      cpu_rst_n      <= (state_d == S_IDLE) || (state_d == S_DONE);

      if (start && can_start) begin
        word_count <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q     <= 8'd0;
`endif
      end

      if (xfer) begin
        case (state)
          S_LEN_HI: len_q[15:8] <= bus.byte_data;
          S_LEN_LO: len_q[7:0]  <= bus.byte_data;
          S_DAT_HI: hi_q        <= bus.byte_data;
          S_DAT_LO: begin
            bus.mem_wdata <= {hi_q, bus.byte_data};
            bus.mem_addr  <= BASE_ADDR + word_count;
          end
          default: ;
        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state != S_CHK) csum_q <= csum_q ^ bus.byte_data;
`endif
      end

      if (state == S_WRITE) word_count <= wc_next[15:0];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one default instance and one at BASE_ADDR=FFFF, MAX_WORDS=2.
module tb_imem_loader;

  logic CLK = 1'b0;
  logic RST;
  logic start0, start1;
  logic cpu_rst_n0, busy0, done0, err0;
  logic cpu_rst_n1, busy1, done1, err1;
  logic [15:0] wc0, wc1;
  logic [3:0] dbg0, dbg1;

  imem_loader_if bus0 ();
  imem_loader_if bus1 ();

  imem_loader dut0 (
    .CLK(CLK), .RST(RST), .start(start0), .bus(bus0),
    .cpu_rst_n(cpu_rst_n0), .busy(busy0), .done(done0), .err(err0),
    .word_count(wc0), .dbg_state(dbg0)
  );

  imem_loader #(.MAX_WORDS(2), .BASE_ADDR(16'hFFFF)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .bus(bus1),
    .cpu_rst_n(cpu_rst_n1), .busy(busy1), .done(done1), .err(err1),
    .word_count(wc1), .dbg_state(dbg1)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;
  int we_ready_overlap = 0;
  logic gap = 1'b0;
  logic [7:0] tb_csum;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: both instances feed one queue since only one loads at a time.
  always @(negedge CLK) begin
    if (bus0.mem_we === 1'b1) begin
      got_q.push_back({bus0.mem_addr, bus0.mem_wdata});
      if (bus0.byte_ready !== 1'b0) we_ready_overlap++;
    end
    if (bus1.mem_we === 1'b1) begin
      got_q.push_back({bus1.mem_addr, bus1.mem_wdata});
      if (bus1.byte_ready !== 1'b0) we_ready_overlap++;
    end
  end

  task automatic pulse_start(input int which);
    @(negedge CLK);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    tb_csum = 8'h00;
    @(posedge CLK);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic count_csum);
    int n;
    logic rdy;
    n = 0;
    if (gap) begin
      @(posedge CLK);
      #1;
    end
    if (which == 0) begin bus0.byte_valid = 1'b1; bus0.byte_data = b; end
    else            begin bus1.byte_valid = 1'b1; bus1.byte_data = b; end
    @(negedge CLK);
    rdy = (which == 0) ? bus0.byte_ready : bus1.byte_ready;
    while (!rdy && n < 50) begin
      @(negedge CLK);
      rdy = (which == 0) ? bus0.byte_ready : bus1.byte_ready;
      n++;
    end
    if (!rdy) check("byte_ready_timeout", 32'(rdy), 32'd1);
    @(posedge CLK);
    #1;
    bus0.byte_valid = 1'b0;
    bus1.byte_valid = 1'b0;
    if (count_csum) tb_csum = tb_csum ^ b;
  endtask

  // Sends the trailing checksum byte when that option is built in.
  task automatic finish_load(input int which);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(which, tb_csum, 1'b0);
`else
    if (which < 0) send_byte(which, 8'h00, 1'b0);
`endif
  endtask

  task automatic wait_end(input int which);
    int n;
    logic fin;
    n = 0;
    @(negedge CLK);
    fin = (which == 0) ? (done0 | err0) : (done1 | err1);
    while (!fin && n < 40) begin
      @(negedge CLK);
      fin = (which == 0) ? (done0 | err0) : (done1 | err1);
      n++;
    end
    if (!fin) check("end_timeout", 32'(fin), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    logic [31:0] g, e;
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    RST = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    bus0.byte_valid = 1'b0; bus0.byte_data = 8'h00;
    bus1.byte_valid = 1'b0; bus1.byte_data = 8'h00;
    tb_csum = 8'h00;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", 32'(dbg0), 32'd0);
    check("rst_byte_ready", 32'(bus0.byte_ready), 32'd0);
    check("rst_mem_we", 32'(bus0.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus0.mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(bus0.mem_wdata), 32'h0);
    check("rst_word_count", 32'(wc0), 32'd0);
    check("rst_flags", {29'd0, busy0, done0, err0}, 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n0), 32'd1);
    RST = 1'b1;

    // Two-word load at base 0
    pulse_start(0);
    check("load_busy", 32'(busy0), 32'd1);
    check("load_cpu_hold", 32'(cpu_rst_n0), 32'd0);
    send_byte(0, 8'h00, 1'b1); send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h12, 1'b1); send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'hAB, 1'b1); send_byte(0, 8'hCD, 1'b1);
    finish_load(0);
    wait_end(0);
    check("two_done_err", {30'd0, done0, err0}, 32'h2);
    check("two_word_count", 32'(wc0), 32'd2);
    check("two_cpu_rst_n", 32'(cpu_rst_n0), 32'd1);
    check("two_hold_addr", {bus0.mem_addr, bus0.mem_wdata}, 32'h0001ABCD);
    exp_q.push_back(32'h00001234);
    exp_q.push_back(32'h0001ABCD);
    check_writes("two");

    // Zero-length load
    pulse_start(0);
    send_byte(0, 8'h00, 1'b1); send_byte(0, 8'h00, 1'b1);
    wait_end(0);
    check("zero_done", 32'(done0), 32'd1);
    check("zero_word_count", 32'(wc0), 32'd0);
    check_writes("zero");

    // Oversize length, then restart clears err
    pulse_start(0);
    send_byte(0, 8'h01, 1'b1); send_byte(0, 8'h01, 1'b1);
    wait_end(0);
    check("big_err_done", {30'd0, done0, err0}, 32'h1);
    check("big_cpu_rst_n", 32'(cpu_rst_n0), 32'd0);
    check_writes("big");
    pulse_start(0);
    check("restart_err", 32'(err0), 32'd0);
    check("restart_busy", 32'(busy0), 32'd1);

    // Reset mid-word with start on the same edge
    send_byte(0, 8'h00, 1'b1); send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    RST = 1'b0;
    start0 = 1'b1;
    @(posedge CLK);
    #1;
    start0 = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_state", 32'(dbg0), 32'd0);
    check("mid_rst_word_count", 32'(wc0), 32'd0);
    check("mid_rst_cpu_rst_n", 32'(cpu_rst_n0), 32'd1);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    repeat (4) @(negedge CLK);
    check("mid_rst_idle", 32'(dbg0), 32'd0);
    check_writes("mid_rst");

    // MAX_WORDS=2 instance: one over the limit is rejected
    pulse_start(1);
    send_byte(1, 8'h00, 1'b1); send_byte(1, 8'h03, 1'b1);
    wait_end(1);
    check("max_over_err", 32'(err1), 32'd1);
    check_writes("max_over");

    // Exactly MAX_WORDS, base FFFF wraps, sparse valid
    gap = 1'b1;
    we_ready_overlap = 0;
    pulse_start(1);
    send_byte(1, 8'h00, 1'b1); send_byte(1, 8'h02, 1'b1);
    send_byte(1, 8'h01, 1'b1); send_byte(1, 8'h02, 1'b1);
    send_byte(1, 8'h03, 1'b1); send_byte(1, 8'h04, 1'b1);
    finish_load(1);
    gap = 1'b0;
    wait_end(1);
    check("wrap_done", 32'(done1), 32'd1);
    check("wrap_word_count", 32'(wc1), 32'd2);
    check("wrap_ready_in_write", 32'(we_ready_overlap), 32'd0);
    exp_q.push_back(32'hFFFF0102);
    exp_q.push_back(32'h00000304);
    check_writes("wrap");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 00^01^12^34 = 27
    pulse_start(0);
    send_byte(0, 8'h00, 1'b1); send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h12, 1'b1); send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h27, 1'b0);
    wait_end(0);
    check("csum_good_done", {30'd0, done0, err0}, 32'h2);
    exp_q.push_back(32'h00001234);
    check_writes("csum_good");
    pulse_start(0);
    send_byte(0, 8'h00, 1'b1); send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h12, 1'b1); send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h26, 1'b0);
    wait_end(0);
    check("csum_bad_err", {30'd0, done0, err0}, 32'h1);
    check("csum_bad_word_count", 32'(wc0), 32'd1);
    exp_q.push_back(32'h00001234);
    check_writes("csum_bad");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
